// File: rtl/pipelined_addsub.sv
// Multi-limb adder/subtractor: one LIMB-wide carry-chain adder reused over
// WIDTH/LIMB cycles, with the carry registered between limbs.
module pipelined_addsub #(
  parameter int unsigned WIDTH = 384,
  parameter int unsigned LIMB  = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             subtract,
  input  logic             Cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   C,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NLIMB = WIDTH / LIMB;
  localparam int unsigned CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [CW-1:0] LAST_LIMB = CW'(NLIMB - 1);

  generate
    if (((WIDTH % LIMB) != 0) || (NLIMB < 1)) begin : g_param_check
      $error("pipelined_addsub: WIDTH must be a non-zero multiple of LIMB");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [WIDTH:0]   r_c;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic [LIMB:0]    w_sum;
  logic [WIDTH-1:0] w_res_next;

  assign w_accept = start && ((r_state == IDLE) || (r_state == FIN));
  assign w_last   = (r_state == RUN) && (r_cnt == LAST_LIMB);

  // One limb of the carry chain; new limb enters the result at the top.
  assign w_sum      = {1'b0, r_a[LIMB-1:0]} + {1'b0, r_b[LIMB-1:0]} + (LIMB+1)'(r_carry);
  assign w_res_next = WIDTH'({w_sum[LIMB-1:0], r_res} >> LIMB);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == LAST_LIMB) w_next = FIN;
      FIN:     w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_c     <= '0;
    end else begin
      r_busy <= (w_next == RUN);
      r_done <= (w_next == FIN);
      if (w_accept) begin
        // Subtraction is A + ~B + 1; the +1 rides in on the initial carry.
        r_a     <= A;
        r_b     <= subtract ? ~B : B;
        r_carry <= subtract | Cin;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a     <= r_a >> LIMB;
        r_b     <= r_b >> LIMB;
        r_carry <= w_sum[LIMB];
        r_res   <= w_res_next;
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_c <= {w_sum[LIMB], w_res_next};
        end
      end
    end
  end

  assign C    = r_c;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised multi-limb adder/subtractor for wide modular-arithmetic datapaths (ECDSA field/scalar ops). It processes operands LIMB bits per cycle through a single LIMB-wide carry-chain adder, with a registered carry between limbs. It extends the fixed 384/128 adder with configurable width and limb size, a subtract mode, synchronous reset, busy status, and a start-ignored-while-busy rule. It sits between the operand register file and the modular reduction / compare logic.

Parameters:
WIDTH, 384, operand width in bits; must be an integer multiple of LIMB.
LIMB, 128, bits processed per cycle (adder width).
NLIMB, WIDTH/LIMB, derived localparam, not overridable; must be >= 1.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  single-cycle request; sampled on a rising edge only when the block is not busy.
subtract  input  1  sampled with start. 0: C = A + B + Cin. 1: C = A - B (Cin ignored).
Cin  input  1  carry-in for add mode; sampled with start.
A  input  WIDTH  operand A; sampled with start.
B  input  WIDTH  operand B; sampled with start.
C  output  WIDTH+1  result. C[WIDTH] is the carry-out. In subtract mode C[WIDTH]=1 means no borrow (A >= B unsigned).
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse; C is valid in that cycle.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; C, busy and done all 0; limb counter 0; operand and carry registers cleared. rst has priority over start in the same cycle.
- States:
  - IDLE: busy=0. On start, go to RUN.
  - RUN: busy=1, lasts exactly NLIMB cycles. Then go to FIN.
  - FIN: busy=0, done=1 for one cycle. Go to IDLE, or straight to RUN if start is high in FIN.
- Accept (start=1 in IDLE or FIN):
  - Latch A and B' = subtract ? ~B : B into shift registers.
  - Carry register = subtract ? 1 : Cin.
  - Limb counter = 0.
- RUN, each cycle k = 0..NLIMB-1:
  - {c, s} = A_sh[LIMB-1:0] + B_sh[LIMB-1:0] + carry.
  - Store s into result limb k.
  - Carry register <= c.
  - Shift A_sh and B_sh right by LIMB.
  - Counter increments.
  - Leave RUN when counter reaches NLIMB-1.
- Latency: start high in cycle 0 means busy is high in cycles 1..NLIMB, and done plus valid C appear in cycle NLIMB+1. Default parameters give 4 cycles.
- C is updated only in the FIN transition.
  - C[WIDTH-1:0] = concatenated limbs; C[WIDTH] = final carry.
  - C holds its value until the next completed operation or reset. It does not change during RUN.
- start while busy=1: ignored entirely. Operands are not re-sampled and the in-flight result is unaffected.
- Back-to-back: start in the FIN cycle is accepted. Throughput is one operation per NLIMB+1 cycles.
- rst mid-RUN: aborts the operation. No done is produced and C returns to 0.
- Arithmetic is modulo 2^WIDTH plus the carry bit. No reduction is performed.
- NLIMB=1: RUN lasts one cycle and latency is 2.
- Elaboration must fail (generate-time check) if WIDTH % LIMB != 0.

Test Plan:
- Carry-out: default params, A = 2^384-1, B = 0, Cin = 1, subtract = 0, start in cycle 0 -> done only in cycle 4; C[383:0] = 0, C[384] = 1; busy high in cycles 1-3.
- Inter-limb carry: A = 2^128-1, B = 1, Cin = 0 -> C = 2^128 (bit 128 set, all other bits 0, C[384] = 0). Repeat with A = 2^256-1 -> C = 2^256.
- Subtract: A = 5, B = 7 -> C[383:0] = 2^384-2, C[384] = 0. Then A = 7, B = 5, Cin = 1 -> C = 2, C[384] = 1 (Cin ignored).
- Handshake: start (A = 1, B = 1) in cycle 0; start (A = 9, B = 9) in cycle 2 -> single done in cycle 4 with C = 2. Start (A = 3, B = 4) in the done cycle -> next done 4 cycles later with C = 7.
- Reset mid-operation: start in cycle 0, rst in cycle 2 -> busy = 0, done never pulses, C = 0. A new start in cycle 4 completes normally in cycle 8.
- Parametrisation: WIDTH = 64, LIMB = 16 and WIDTH = 32, LIMB = 32, 1000 random add/sub vectors compared against a behavioural model -> all match; latency is 5 and 2 cycles respectively.
